if_fetch_unit: RTL and testbench

//  Decoupled instruction-fetch stage; the next generation of the single-cycle IF stage.

---
 rtl/if_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 73 +++++++
 rtl/if_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the decoupled instruction-fetch stage.
// Covers the queue entry layout, the redirect source encoding and a PC alignment helper.
package if_pkg;

   localparam int ILEN    = 32;
   localparam int PC_STEP = 4;

   typedef struct packed {
      logic [31:0]     pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      RD_NONE,
      RD_ID,
      RD_EX
   } redirect_src_e;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a flush input.
// Flush empties the FIFO and wins over a push in the same cycle. Push while full is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             empty_o,
   output logic             full_o,
   output logic [CW-1:0]    count_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   // Explicit wrap so that non-power-of-2 depths work too.
   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
         if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign count_o = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Decoupled IF stage: credit-limited PC generator, in-order response tagging and an
// instruction queue toward ID, with EX/ID redirects flushing and dropping stale reads.
module if_fetch_unit
   import if_pkg::*;
#(
   parameter logic [31:0] CPU_RESET_VECTOR = 32'h0,
   parameter int          FIFO_DEPTH       = 4,
   parameter int          MAX_OUTSTANDING  = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        i_id_redirect,
   input  logic [31:0] i_id_redirect_pc,
   input  logic        i_ex_redirect,
   input  logic [31:0] i_ex_redirect_pc,
   output logic        o_imem_req_valid,
   input  logic        i_imem_req_ready,
   output logic [31:0] o_imem_req_addr,
   input  logic        i_imem_rsp_valid,
   input  logic [31:0] i_imem_rsp_data,
   output logic        o_if_valid,
   input  logic        i_id_ready,
   output logic [31:0] o_if_pc,
   output logic [31:0] o_if_pc_p4,
   output logic [31:0] o_if_instr
);

   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int QW = $clog2(FIFO_DEPTH + 1);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [OW-1:0] outstanding_q, outstanding_d;
   logic [OW-1:0] drop_q, drop_d;
   redirect_src_e rd_src;
   logic [31:0]   rd_target;
   logic          redirect;
   logic          req_accept, rsp_keep, if_pop;
   logic [QW:0]   credit_used;
   fetch_entry_t  q_head, q_push_entry;
   logic          q_empty, q_full;
   logic [QW-1:0] q_count;
   logic [31:0]   tag_head;
   logic          tag_empty, tag_full;
   logic [OW-1:0] tag_count;

   always_comb begin
      rd_src    = RD_NONE;
      rd_target = '0;
      if (i_ex_redirect) begin
         rd_src    = RD_EX;
         rd_target = i_ex_redirect_pc;
      end else if (i_id_redirect) begin
         rd_src    = RD_ID;
         rd_target = i_id_redirect_pc;
      end
   end

   assign redirect = (rd_src != RD_NONE);

   // Handshakes: a transfer happens on a cycle where valid && ready are both high; a
   // request holds valid/addr until then unless a redirect cancels it. Responses have
   // no ready and are always absorbed, which the credit check below guarantees.
   assign credit_used      = (QW+1)'(outstanding_q) + (QW+1)'(q_count);
   assign o_imem_req_valid = rstn && (credit_used < (QW+1)'(FIFO_DEPTH))
                             && (outstanding_q < OW'(MAX_OUTSTANDING)) && !redirect;
   assign o_imem_req_addr  = fetch_pc_q;
   assign req_accept       = o_imem_req_valid && i_imem_req_ready;
   assign rsp_keep         = i_imem_rsp_valid && (drop_q == '0);

   always_comb begin
      outstanding_d = outstanding_q + OW'(req_accept) - OW'(i_imem_rsp_valid);
      drop_d        = drop_q;
      fetch_pc_d    = fetch_pc_q;
      if (i_imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - OW'(1);
      if (req_accept) fetch_pc_d = fetch_pc_q + 32'(PC_STEP);
      if (redirect) begin
         // Everything still in flight after this cycle belongs to the old path.
         drop_d     = outstanding_d;
         fetch_pc_d = align_word(rd_target);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fetch_pc_q    <= align_word(CPU_RESET_VECTOR);
         outstanding_q <= '0;
         drop_q        <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
      end
   end

   sync_fifo #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .flush_i (redirect),
      .push_i  (req_accept),
      .data_i  (fetch_pc_q),
      .pop_i   (rsp_keep),
      .data_o  (tag_head),
      .empty_o (tag_empty),
      .full_o  (tag_full),
      .count_o (tag_count)
   );

   assign q_push_entry.pc    = tag_head;
   assign q_push_entry.instr = i_imem_rsp_data;

   sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_instr_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .flush_i (redirect),
      .push_i  (rsp_keep),
      .data_i  (q_push_entry),
      .pop_i   (if_pop),
      .data_o  (q_head),
      .empty_o (q_empty),
      .full_o  (q_full),
      .count_o (q_count)
   );

   assign o_if_valid = !q_empty && !redirect;
   assign if_pop     = o_if_valid && i_id_ready;
   assign o_if_pc    = o_if_valid ? q_head.pc : '0;
   assign o_if_pc_p4 = o_if_valid ? q_head.pc + 32'(PC_STEP) : '0;
   assign o_if_instr = o_if_valid ? q_head.instr : '0;

   rsp_needs_outstanding: assert property (@(posedge clk) disable iff (!rstn)
      i_imem_rsp_valid |-> (outstanding_q != '0));
   tags_match_live_reads: assert property (@(posedge clk) disable iff (!rstn)
      tag_count == (outstanding_q - drop_q));
   tag_present_for_rsp: assert property (@(posedge clk) disable iff (!rstn)
      rsp_keep |-> !tag_empty);
   no_tag_overflow: assert property (@(posedge clk) disable iff (!rstn)
      !(tag_full && req_accept));
   no_queue_overflow: assert property (@(posedge clk) disable iff (!rstn)
      !(q_full && rsp_keep && !if_pop));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed phases plus a randomized soak for if_fetch_unit, checked against a
// program-order model of the fetch stream and a latency-randomized memory model.
module tb_if_fetch_unit;

   localparam int MAX_OUT = 2;

   logic        clk;
   logic        rstn;
   logic        i_id_redirect;
   logic [31:0] i_id_redirect_pc;
   logic        i_ex_redirect;
   logic [31:0] i_ex_redirect_pc;
   logic        o_imem_req_valid;
   logic        i_imem_req_ready;
   logic [31:0] o_imem_req_addr;
   logic        i_imem_rsp_valid;
   logic [31:0] i_imem_rsp_data;
   logic        o_if_valid;
   logic        i_id_ready;
   logic [31:0] o_if_pc;
   logic [31:0] o_if_pc_p4;
   logic [31:0] o_if_instr;

   if_fetch_unit #(
      .CPU_RESET_VECTOR (32'h0),
      .FIFO_DEPTH       (4),
      .MAX_OUTSTANDING  (MAX_OUT)
   ) dut (
      .clk              (clk),
      .rstn             (rstn),
      .i_id_redirect    (i_id_redirect),
      .i_id_redirect_pc (i_id_redirect_pc),
      .i_ex_redirect    (i_ex_redirect),
      .i_ex_redirect_pc (i_ex_redirect_pc),
      .o_imem_req_valid (o_imem_req_valid),
      .i_imem_req_ready (i_imem_req_ready),
      .o_imem_req_addr  (o_imem_req_addr),
      .i_imem_rsp_valid (i_imem_rsp_valid),
      .i_imem_rsp_data  (i_imem_rsp_data),
      .o_if_valid       (o_if_valid),
      .i_id_ready       (i_id_ready),
      .o_if_pc          (o_if_pc),
      .o_if_pc_p4       (o_if_pc_p4),
      .o_if_instr       (o_if_instr)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   // Reference model: program-order PC of the next instruction ID should see, next
   // request address, and the memory's in-flight reads with their delivery cycles.
   logic [31:0] exp_pc;
   logic [31:0] exp_fetch;
   logic [31:0] exp_q[$];
   int          due_q[$];
   logic [31:0] acc_log[$];
   logic [31:0] pop_log[$];
   int          last_due;
   int          lat_min, lat_max;
   int          n_acc;

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      exp_pc    = 32'h0;
      exp_fetch = 32'h0;
      exp_q.delete();
      due_q.delete();
      pop_log.delete();
      acc_log.delete();
      last_due  = cyc;
   endtask

   task automatic set_redirect(input logic ex, input logic [31:0] ex_pc,
                               input logic id, input logic [31:0] id_pc);
      i_ex_redirect    = ex;
      i_ex_redirect_pc = ex_pc;
      i_id_redirect    = id;
      i_id_redirect_pc = id_pc;
   endtask

   // One cycle, entered and left at a falling edge. Inputs for the cycle are already set
   // by the caller; the memory model drives the response, then outputs are sampled.
   task automatic tick();
      logic        redir;
      logic [31:0] tgt;
      logic [31:0] a;
      int          lat, due;
      if (exp_q.size() > 0 && due_q[0] <= cyc) begin
         a = exp_q.pop_front();
         void'(due_q.pop_front());
         i_imem_rsp_valid = 1'b1;
         i_imem_rsp_data  = mem_fn(a);
      end else begin
         i_imem_rsp_valid = 1'b0;
         i_imem_rsp_data  = $urandom;
      end
      #1;
      redir = i_ex_redirect || i_id_redirect;
      tgt   = i_ex_redirect ? i_ex_redirect_pc : i_id_redirect_pc;
      if (redir) begin
         check("req_valid_during_redirect", 32'(o_imem_req_valid), 32'd0);
         check("if_valid_during_redirect", 32'(o_if_valid), 32'd0);
      end
      if (o_imem_req_valid && i_imem_req_ready) begin
         check("req_addr", o_imem_req_addr, exp_fetch);
         lat = $urandom_range(lat_max, lat_min);
         due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
         last_due = due;
         exp_q.push_back(o_imem_req_addr);
         due_q.push_back(due);
         acc_log.push_back(o_imem_req_addr);
         exp_fetch = exp_fetch + 32'd4;
         n_acc++;
         check("outstanding_bound", 32'(exp_q.size() > MAX_OUT), 32'd0);
      end
      if (o_if_valid && i_id_ready) begin
         check("if_pc", o_if_pc, exp_pc);
         check("if_pc_p4", o_if_pc_p4, exp_pc + 32'd4);
         check("if_instr", o_if_instr, mem_fn(exp_pc));
         pop_log.push_back(o_if_pc);
         exp_pc = exp_pc + 32'd4;
      end
      if (redir) begin
         exp_fetch = {tgt[31:2], 2'b00};
         exp_pc    = {tgt[31:2], 2'b00};
         pop_log.delete();
         acc_log.delete();
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_valid"}, 32'(o_imem_req_valid), 32'd0);
      check({tag, "_req_addr"}, o_imem_req_addr, 32'h0);
      check({tag, "_if_valid"}, 32'(o_if_valid), 32'd0);
      check({tag, "_if_pc"}, o_if_pc, 32'h0);
      check({tag, "_if_pc_p4"}, o_if_pc_p4, 32'h0);
      check({tag, "_if_instr"}, o_if_instr, 32'h0);
   endtask

   task automatic check_first_pop(input string tag, input logic [31:0] exp_v);
      check({tag, "_seen"}, 32'(pop_log.size() > 0), 32'd1);
      if (pop_log.size() > 0) check(tag, pop_log[0], exp_v);
   endtask

   initial begin
      int r;
      rstn             = 1'b0;
      i_imem_req_ready = 1'b0;
      i_imem_rsp_valid = 1'b0;
      i_imem_rsp_data  = 32'h0;
      i_id_ready       = 1'b0;
      set_redirect(1'b0, 32'h0, 1'b0, 32'h0);
      lat_min = 1;
      lat_max = 1;
      @(negedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);

      // Phase 1: streaming with ready memory and 1-cycle latency.
      rstn             = 1'b1;
      i_imem_req_ready = 1'b1;
      i_id_ready       = 1'b1;
      model_reset();
      #1;
      check("first_req_no_dead_cycle", 32'(o_imem_req_valid), 32'd1);
      for (int i = 0; i < 20; i++) tick();
      check("stream_seen", 32'(pop_log.size() >= 3), 32'd1);
      if (pop_log.size() >= 3) begin
         check("stream_pc0", pop_log[0], 32'h0);
         check("stream_pc1", pop_log[1], 32'h4);
         check("stream_pc2", pop_log[2], 32'h8);
      end

      // Phase 2: ID stalled, queue must fill to exactly FIFO_DEPTH.
      i_id_ready = 1'b0;
      set_redirect(1'b1, 32'h40, 1'b0, 32'h0);
      tick();
      set_redirect(1'b0, 32'h0, 1'b0, 32'h0);
      n_acc = 0;
      for (int i = 0; i < 15; i++) tick();
      check("stall_accepts", 32'(n_acc), 32'd4);
      check("stall_req_valid", 32'(o_imem_req_valid), 32'd0);
      check("stall_if_valid", 32'(o_if_valid), 32'd1);
      check("stall_head_pc", o_if_pc, 32'h40);
      i_id_ready = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      check("stall_no_loss", 32'(pop_log.size() >= 4), 32'd1);

      // Phase 3: two reads in flight, then EX redirect.
      lat_min = 3;
      lat_max = 3;
      for (int i = 0; i < 20 && exp_q.size() != 2; i++) tick();
      check("two_outstanding", 32'(exp_q.size()), 32'd2);
      set_redirect(1'b1, 32'h100, 1'b0, 32'h0);
      tick();
      set_redirect(1'b0, 32'h0, 1'b0, 32'h0);
      for (int i = 0; i < 20; i++) tick();
      check_first_pop("ex_redirect_pc", 32'h100);

      // Phase 4: EX beats ID in the same cycle.
      lat_min = 1;
      lat_max = 1;
      set_redirect(1'b1, 32'h200, 1'b1, 32'h300);
      tick();
      set_redirect(1'b0, 32'h0, 1'b0, 32'h0);
      for (int i = 0; i < 15; i++) tick();
      check_first_pop("ex_over_id_pc", 32'h200);

      // Phase 5: memory not ready, request must hold steady.
      i_imem_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      set_redirect(1'b0, 32'h0, 1'b1, 32'h500);
      tick();
      set_redirect(1'b0, 32'h0, 1'b0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_req_valid", 32'(o_imem_req_valid), 32'd1);
         check("hold_req_addr", o_imem_req_addr, 32'h500);
      end
      n_acc = 0;
      i_imem_req_ready = 1'b1;
      tick();
      i_imem_req_ready = 1'b0;
      tick();
      check("hold_single_accept", 32'(n_acc), 32'd1);
      check("hold_next_addr", o_imem_req_addr, 32'h504);
      i_imem_req_ready = 1'b1;
      for (int i = 0; i < 10; i++) tick();

      // Phase 6: misaligned redirect near the top of memory, wrap, then reset mid-burst.
      set_redirect(1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0);
      tick();
      set_redirect(1'b0, 32'h0, 1'b0, 32'h0);
      for (int i = 0; i < 6; i++) tick();
      check("wrap_accepts", 32'(acc_log.size() >= 2), 32'd1);
      if (acc_log.size() >= 2) begin
         check("wrap_addr0", acc_log[0], 32'hFFFF_FFFC);
         check("wrap_addr1", acc_log[1], 32'h0);
      end
      check_first_pop("wrap_first_pc", 32'hFFFF_FFFC);
      rstn             = 1'b0;
      i_imem_rsp_valid = 1'b0;
      #1;
      check_reset_outputs("midreset");
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      model_reset();
      for (int i = 0; i < 10; i++) tick();
      check_first_pop("after_reset_pc", 32'h0);

      // Phase 7: randomized soak.
      lat_min = 1;
      lat_max = 4;
      for (int i = 0; i < 400; i++) begin
         i_imem_req_ready = ($urandom_range(3, 0) != 0);
         i_id_ready       = ($urandom_range(3, 0) != 0);
         r = $urandom_range(99, 0);
         set_redirect(r < 4, $urandom, (r < 2) || (r >= 4 && r < 8), $urandom);
         tick();
      end
      set_redirect(1'b0, 32'h0, 1'b0, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
